// File: rtl/cia_serial_seq.sv
// cia_serial_seq: CIA serial port sequencer, TX byte FIFO -> SDR writes, SDR -> RX byte stream.
// Ports: phi2_up/dn strobes, s_* TX in, m_* RX out, sp_* register port, txmode, busy; RX via CIA_SERIAL_SEQ_RX_EN.
module cia_serial_seq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_up,
  input  logic       phi2_dn,
  input  logic       mode_req,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       txmode,
  output logic       sp_we,
  output logic [3:0] sp_addr,
  output logic [7:0] sp_data,
  input  logic [7:0] sp_regs,
  input  logic       sp_int,
  output logic       busy,
  output logic       rx_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SWITCH, TX, RX} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    outst;
  logic [1:0]    gap;
  logic          sw_cnt;
  logic          live;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          wr_go;
  logic          wr_end;
  logic          int_s;
  logic          mreq;
  logic          go_sw;

`ifdef CIA_SERIAL_SEQ_RX_EN
  logic [1:0]    rx_sh;
  assign mreq = mode_req;
`else
  logic          unused_rx;
  assign mreq       = 1'b1;
  assign unused_rx  = ^{mode_req, m_ready, sp_regs};
  assign m_valid    = 1'b0;
  assign m_data     = 8'h00;
  assign rx_overrun = 1'b0;
`endif

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign s_ready = live & ~full;
  assign push    = s_valid & s_ready;
  assign wr_end  = sp_we & phi2_dn;
  assign pop     = wr_end;
  assign int_s   = sp_int & phi2_dn;
  assign sp_addr = sp_we ? 4'hC : 4'h0;
  assign sp_data = sp_we ? mem[rd_ptr] : 8'h00;
  assign busy    = (state == SWITCH) |
                   (state == TX) | ~empty;

  // SDR holds one byte and SR another: at most two in flight,
  // and the SDR->SR transfer needs three strobes of quiet.
  assign wr_go = (state == TX) & phi2_up & ~sp_we &
                 ~empty & (outst != 2'd2) &
                 (gap == 2'd0);

  always_comb begin
    go_sw = 1'b0;
    unique case (state)
      IDLE:   go_sw = (mreq != txmode);
      SWITCH: go_sw = 1'b0;
      TX:     go_sw = ~mreq & empty &
                      (outst == 2'd0) & ~sp_we;
      RX:     go_sw = mreq;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state  <= IDLE;
      txmode <= 1'b0;
      sp_we  <= 1'b0;
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      outst  <= '0;
      gap    <= '0;
      sw_cnt <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
`ifdef CIA_SERIAL_SEQ_RX_EN
      m_valid    <= 1'b0;
      m_data     <= '0;
      rx_overrun <= 1'b0;
      rx_sh      <= '0;
`endif
    end else begin
      live <= 1'b1;

      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (wr_end)
        gap <= 2'd3;
      else if (phi2_dn && gap != 2'd0)
        gap <= gap - 2'd1;

      if (wr_go)
        sp_we <= 1'b1;
      else if (wr_end)
        sp_we <= 1'b0;

`ifdef CIA_SERIAL_SEQ_RX_EN
      if (m_valid && m_ready)
        m_valid <= 1'b0;
`endif

      unique case (state)
        IDLE: state <= txmode ? TX : RX;
        SWITCH: begin
          if (phi2_dn) begin
            if (sw_cnt)
              state <= txmode ? TX : RX;
            sw_cnt <= 1'b1;
          end
        end
        TX: begin
          // write end and interrupt together cancel out
          if (wr_end && !int_s)
            outst <= outst + 2'd1;
          else if (!wr_end && int_s && outst != 2'd0)
            outst <= outst - 2'd1;
        end
        RX: begin
`ifdef CIA_SERIAL_SEQ_RX_EN
          // SDR is valid two strobes after the interrupt
          if (phi2_dn) begin
            rx_sh <= {rx_sh[0], sp_int};
            if (rx_sh[1]) begin
              if (m_valid && !m_ready) begin
                rx_overrun <= 1'b1;
              end else begin
                m_data  <= sp_regs;
                m_valid <= 1'b1;
              end
            end
          end
`endif
        end
      endcase

      if (go_sw) begin
        state  <= SWITCH;
        txmode <= ~txmode;
        outst  <= '0;
        sw_cnt <= 1'b0;
`ifdef CIA_SERIAL_SEQ_RX_EN
        rx_overrun <= 1'b0;
        rx_sh      <= '0;
`endif
      end
    end
  end

endmodule
